// File: rtl/mem_sram_ctrl_if.sv
// Word-oriented memory request bus between a requester and the SRAM controller.
// Latency: n/a (wiring only).
// Backpressure: requester holds mem_cs/mem_burst; the responder paces words with mem_busy/mem_ack.
interface mem_sram_ctrl_if #(
  parameter int ADDR_BITS = 24
);
  logic                 mem_cs;
  logic                 mem_we;
  logic [ADDR_BITS-3:0] mem_addr;
  logic [3:0]           mem_sel;
  logic                 mem_burst;
  logic [31:0]          mem_din;
  logic [31:0]          mem_dout;
  logic                 mem_busy;
  logic                 mem_ack;

  modport master (
    output mem_cs, mem_we, mem_addr, mem_sel, mem_burst, mem_din,
    input  mem_dout, mem_busy, mem_ack
  );

  modport slave (
    input  mem_cs, mem_we, mem_addr, mem_sel, mem_burst, mem_din,
    output mem_dout, mem_busy, mem_ack
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-side responder: runs timed access cycles on an asynchronous 32-bit SRAM, singles and bursts.
// Latency: ack READ_CYCLES+1 / WRITE_CYCLES+1 cycles after the request edge; burst word period CYCLES+2.
// Backpressure: one word in flight; requests are only sampled in IDLE or the burst load slot.
module mem_sram_ctrl #(
  parameter int ADDR_BITS      = 24,
  parameter int READ_CYCLES    = 2,
  parameter int WRITE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_sram_ctrl_if.slave       bus,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [3:0]           sram_be_n,
  output logic [ADDR_BITS-3:0] sram_addr,
  output logic [31:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [31:0]          sram_dq_i
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_ACK, S_RECOVER} state_t;

  localparam logic [3:0] RD_INIT  = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_INIT  = 4'(WRITE_CYCLES - 1);
  localparam logic [3:0] REC_INIT = 4'(RECOVER_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 burst_q, burst_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-3:0] addr_q, addr_d;
  logic [3:0]           be_n_q, be_n_d;
  logic [31:0]          dq_o_q, dq_o_d;
  logic [31:0]          dout_q, dout_d;
  logic                 ack_q, ack_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 wen_q, wen_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 load;

  // Next state, request latching, and strobes derived from the next state so every pad is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_n_d  = be_n_q;
    dq_o_d  = dq_o_q;
    dout_d  = dout_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_cs) load = 1'b1;
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          dout_d  = sram_dq_i;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACK: begin
        // A continuing burst uses a single recover cycle as the slot where the next word is loaded.
        state_d = S_RECOVER;
        if (bus.mem_burst && bus.mem_cs) begin
          burst_d = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          burst_d = 1'b0;
          cnt_d   = REC_INIT;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 4'd0) begin
          burst_d = 1'b0;
          if (burst_q && bus.mem_cs) load    = 1'b1;
          else                       state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Direction is re-latched per word, so a burst may change between read and write.
    if (load) begin
      addr_d  = bus.mem_addr;
      be_n_d  = ~bus.mem_sel;
      dq_o_d  = bus.mem_din;
      we_d    = bus.mem_we;
      state_d = bus.mem_we ? S_WRITE : S_READ;
      cnt_d   = bus.mem_we ? WR_INIT : RD_INIT;
    end

    ce_n_d  = !((state_d == S_READ) || (state_d == S_WRITE) || (state_d == S_ACK));
    oe_n_d  = (state_d != S_READ);
    wen_d   = (state_d != S_WRITE);
    // Keep driving the pad through the ack cycle after a write for data hold time.
    dq_oe_d = (state_d == S_WRITE) || ((state_d == S_ACK) && we_d);
    ack_d   = (state_d == S_ACK);
  end

  // State, datapath and strobe registers; asynchronous reset parks the SRAM deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      burst_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_n_q  <= 4'hF;
      dq_o_q  <= 32'h0;
      dout_q  <= 32'h0;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      wen_q   <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      dq_o_q  <= dq_o_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      wen_q   <= wen_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign bus.mem_dout = dout_q;
  assign bus.mem_ack  = ack_q;
  assign bus.mem_busy = (state_q != S_IDLE);

  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = wen_q;
  assign sram_be_n  = be_n_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: default-timing instance plus a 1-cycle read/write instance sharing one SRAM model.
// Latency: n/a.
// Backpressure: requester waits for each mem_ack before advancing a burst.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Requester signals, steered to one of the two controllers.
  logic        use_fast = 1'b0;
  logic        req_cs = 1'b0, req_we = 1'b0, req_burst = 1'b0;
  logic [21:0] req_addr = '0;
  logic [3:0]  req_sel = 4'h0;
  logic [31:0] req_din = 32'h0;

  mem_sram_ctrl_if #(.ADDR_BITS(24)) bus_m ();
  mem_sram_ctrl_if #(.ADDR_BITS(24)) bus_f ();

  assign bus_m.mem_cs    = req_cs & ~use_fast;
  assign bus_f.mem_cs    = req_cs & use_fast;
  assign bus_m.mem_we    = req_we;
  assign bus_f.mem_we    = req_we;
  assign bus_m.mem_burst = req_burst;
  assign bus_f.mem_burst = req_burst;
  assign bus_m.mem_addr  = req_addr;
  assign bus_f.mem_addr  = req_addr;
  assign bus_m.mem_sel   = req_sel;
  assign bus_f.mem_sel   = req_sel;
  assign bus_m.mem_din   = req_din;
  assign bus_f.mem_din   = req_din;

  logic        m_ce_n, m_oe_n, m_we_n, m_dq_oe, f_ce_n, f_oe_n, f_we_n, f_dq_oe;
  logic [3:0]  m_be_n, f_be_n;
  logic [21:0] m_addr, f_addr;
  logic [31:0] m_dq_o, f_dq_o, sram_rd;

  mem_sram_ctrl #(.ADDR_BITS(24), .READ_CYCLES(2), .WRITE_CYCLES(2), .RECOVER_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m),
    .sram_ce_n(m_ce_n), .sram_oe_n(m_oe_n), .sram_we_n(m_we_n), .sram_be_n(m_be_n),
    .sram_addr(m_addr), .sram_dq_o(m_dq_o), .sram_dq_oe(m_dq_oe), .sram_dq_i(sram_rd)
  );

  mem_sram_ctrl #(.ADDR_BITS(24), .READ_CYCLES(1), .WRITE_CYCLES(1), .RECOVER_CYCLES(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .bus(bus_f),
    .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n), .sram_we_n(f_we_n), .sram_be_n(f_be_n),
    .sram_addr(f_addr), .sram_dq_o(f_dq_o), .sram_dq_oe(f_dq_oe), .sram_dq_i(sram_rd)
  );

  // Observed side of whichever controller is under test.
  logic        a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_ack, a_busy;
  logic [3:0]  a_be_n;
  logic [21:0] a_addr;
  logic [31:0] a_dq_o, a_dout;
  assign a_ce_n  = use_fast ? f_ce_n  : m_ce_n;
  assign a_oe_n  = use_fast ? f_oe_n  : m_oe_n;
  assign a_we_n  = use_fast ? f_we_n  : m_we_n;
  assign a_dq_oe = use_fast ? f_dq_oe : m_dq_oe;
  assign a_be_n  = use_fast ? f_be_n  : m_be_n;
  assign a_addr  = use_fast ? f_addr  : m_addr;
  assign a_dq_o  = use_fast ? f_dq_o  : m_dq_o;
  assign a_ack   = use_fast ? bus_f.mem_ack  : bus_m.mem_ack;
  assign a_busy  = use_fast ? bus_f.mem_busy : bus_m.mem_busy;
  assign a_dout  = use_fast ? bus_f.mem_dout : bus_m.mem_dout;

  // Asynchronous SRAM model, 64 words, byte-lane writes.
  logic [31:0] mem_a [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 32'hA5000000 | 32'(i);
    mem_a[16] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (!a_ce_n && !a_we_n && a_dq_oe)
        for (int b = 0; b < 4; b++)
          if (!a_be_n[b]) mem_a[a_addr[5:0]][8*b +: 8] = a_dq_o[8*b +: 8];
    end
  end
  assign sram_rd = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[5:0]] : 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor counters, cleared at the start of every sequence.
  logic   mon_en = 1'b0;
  logic   prev_ack = 1'b0;
  int     c0 = 0, rel, n_ack, first_ack_rel, last_ack_cyc, oe_cnt, we_cnt, dqoe_cnt, ce_hi_busy, busy_low_rel;
  logic [3:0] be_seen;
  int     gaps[$];

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - c0 + 1;
      if (a_ack) begin
        check("ack_not_back_to_back", 32'(prev_ack), 32'd0);
        if (n_ack == 0) first_ack_rel = rel;
        else            gaps.push_back(cyc - last_ack_cyc);
        last_ack_cyc = cyc;
        n_ack++;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          check("ack_dir", 32'(a_dq_oe), 32'(!e.rd));
          if (e.rd) check("rd_data", a_dout, e.data);
        end
      end
      if (!a_oe_n) oe_cnt++;
      if (!a_we_n) begin we_cnt++; be_seen = a_be_n; end
      if (a_dq_oe) dqoe_cnt++;
      if (a_busy && a_ce_n) ce_hi_busy++;
      if (!a_busy && busy_low_rel == 0) busy_low_rel = rel;
      prev_ack = a_ack;
    end
  end

  // Issue n words starting at a0; wep[k] selects write for word k; cs drops after word 'drop'.
  task automatic run_seq(input int n, input logic [21:0] a0, input logic [3:0] wep,
                         input logic [3:0] sel, input logic [31:0] d0, input int drop);
    logic got, done;
    int   nexp;
    sb_t  e;
    n_ack = 0; first_ack_rel = 0; last_ack_cyc = 0; oe_cnt = 0; we_cnt = 0;
    dqoe_cnt = 0; ce_hi_busy = 0; busy_low_rel = 0; be_seen = 4'h0; prev_ack = 1'b0;
    gaps.delete();
    for (int k = 0; k < n; k++) begin
      req_cs    = 1'b1;
      req_we    = wep[k];
      req_addr  = a0 + 22'(k);
      req_sel   = sel;
      req_din   = d0 + 32'(k) * 32'h01010101;
      req_burst = (k < n - 1);
      e.rd      = !wep[k];
      e.data    = mem_a[req_addr[5:0]];
      sb.push_back(e);
      @(posedge clk); #1;
      if (k == 0) begin c0 = cyc; mon_en = 1'b1; end
      if (k == n - 1 || k == drop) begin
        req_cs = 1'b0; req_burst = 1'b0;
        break;
      end
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin @(negedge clk); got = a_ack; end
      if (!got) begin
        check("ack_timeout", 32'd0, 32'd1);
        req_cs = 1'b0; req_burst = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    nexp = (drop < n) ? drop + 1 : n;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk); #1;
      done = (n_ack >= nexp) && !a_busy;
    end
    check("seq_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ce_n", 32'(m_ce_n), 32'd1);
    check("rst_oe_n", 32'(m_oe_n), 32'd1);
    check("rst_we_n", 32'(m_we_n), 32'd1);
    check("rst_be_n", 32'(m_be_n), 32'hF);
    check("rst_dq_oe", 32'(m_dq_oe), 32'd0);
    check("rst_busy", 32'(bus_m.mem_busy), 32'd0);
    check("rst_ack", 32'(bus_m.mem_ack), 32'd0);
    check("rst_dout", bus_m.mem_dout, 32'h0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single read of word 0x10.
    run_seq(1, 22'h10, 4'b0000, 4'hF, 32'h0, 99);
    check("rd_n_ack", 32'(n_ack), 32'd1);
    check("rd_ack_cycle", 32'(first_ack_rel), 32'd3);
    check("rd_oe_cycles", 32'(oe_cnt), 32'd2);
    check("rd_busy_low_cycle", 32'(busy_low_rel), 32'd5);

    // Single write, sel 0101.
    run_seq(1, 22'h5, 4'b0001, 4'b0101, 32'h11223344, 99);
    check("wr_n_ack", 32'(n_ack), 32'd1);
    check("wr_be_n", 32'(be_seen), 32'b1010);
    check("wr_we_cycles", 32'(we_cnt), 32'd2);
    check("wr_dq_oe_cycles", 32'(dqoe_cnt), 32'd3);
    check("wr_mem5", mem_a[5], 32'hA5220044);

    // Four-word burst read, words 8..11.
    run_seq(4, 22'h8, 4'b0000, 4'hF, 32'h0, 99);
    check("brd_n_ack", 32'(n_ack), 32'd4);
    check("brd_first_ack", 32'(first_ack_rel), 32'd3);
    check("brd_n_gaps", 32'(gaps.size()), 32'd3);
    foreach (gaps[i]) check("brd_gap", 32'(gaps[i]), 32'd4);
    check("brd_ce_high_busy", 32'(ce_hi_busy), 32'd4);
    check("brd_oe_cycles", 32'(oe_cnt), 32'd8);

    // Three-word burst write, cs dropped during the second word.
    run_seq(3, 22'd20, 4'b0111, 4'hF, 32'h10203040, 1);
    check("bwr_n_ack", 32'(n_ack), 32'd2);
    check("bwr_gap", (gaps.size() == 1) ? 32'(gaps[0]) : 32'hFFFF_FFFF, 32'd4);
    check("bwr_we_cycles", 32'(we_cnt), 32'd4);
    check("bwr_mem20", mem_a[20], 32'h10203040);
    check("bwr_mem21", mem_a[21], 32'h11213141);
    check("bwr_mem22", mem_a[22], 32'hA5000016);

    // Reset in the middle of a write.
    req_cs = 1'b1; req_we = 1'b1; req_addr = 22'd40; req_sel = 4'hF; req_din = 32'hCAFEF00D; req_burst = 1'b0;
    @(posedge clk); #1;
    req_cs = 1'b0;
    @(negedge clk);
    check("mid_wr_active", 32'(m_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce_n", 32'(m_ce_n), 32'd1);
    check("mid_rst_we_n", 32'(m_we_n), 32'd1);
    check("mid_rst_dq_oe", 32'(m_dq_oe), 32'd0);
    check("mid_rst_be_n", 32'(m_be_n), 32'hF);
    check("mid_rst_addr", 32'(m_addr), 32'd0);
    check("mid_rst_dq_o", m_dq_o, 32'h0);
    check("mid_rst_busy", 32'(bus_m.mem_busy), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Fresh read after reset.
    run_seq(1, 22'd3, 4'b0000, 4'hF, 32'h0, 99);
    check("post_rst_n_ack", 32'(n_ack), 32'd1);
    check("post_rst_ack_cycle", 32'(first_ack_rel), 32'd3);

    // One-cycle timing: alternating read/write burst on words 30..33.
    use_fast = 1'b1;
    @(posedge clk); #1;
    run_seq(4, 22'd30, 4'b1010, 4'hF, 32'h55AA0000, 99);
    check("fast_n_ack", 32'(n_ack), 32'd4);
    check("fast_first_ack", 32'(first_ack_rel), 32'd2);
    check("fast_n_gaps", 32'(gaps.size()), 32'd3);
    foreach (gaps[i]) check("fast_gap", 32'(gaps[i]), 32'd3);
    check("fast_we_cycles", 32'(we_cnt), 32'd2);
    check("fast_oe_cycles", 32'(oe_cnt), 32'd2);
    check("fast_mem31", mem_a[31], 32'h56AB0101);
    check("fast_mem33", mem_a[33], 32'h58AD0303);
    check("fast_mem32", mem_a[32], 32'hA5000020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
